zir_uart_rx: RTL and testbench

UART receiver for the IR configure UART (`iIR_UART_RxD`), clocked from the PLL global clock domain alongside the PSRAM and debug-UART logic. It is the receiving end of the 8-N-1 serial format our transmitters already drive. The block synchronizes and filters the pin, recovers bytes with a mid-bit-sampling state machine, and buffers them in a 4-entry first-word-fall-through FIFO for the IR control logic to pop.

---
 rtl/zir_uart_pkg.sv | 16 +
 rtl/zir_uart_rx_fifo.sv | 60 ++++++
 rtl/zir_uart_rx.sv | 178 +++++++++++++++++
 tb/tb_zir_uart_rx.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/zir_uart_pkg.sv
// Shared types and constants for the IR configure UART receiver.
package zir_uart_pkg;

    localparam int UART_DATA_W             = 8;
    localparam int CLKS_PER_BIT_48M_115200 = 417;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4,
        ST_BREAK  = 3'd5
    } rxState_t;

endpackage

// File: rtl/zir_uart_rx_fifo.sv
// First-word-fall-through byte FIFO with sticky overrun flag.
// Handshake: the head word in oData is valid while oEmpty=0; iRdEn=1 in such a cycle pops it.
module zir_uart_rx_fifo
    import zir_uart_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int WIDTH = UART_DATA_W
) (
    input  logic             iClk,
    input  logic             iRst_N,
    input  logic             iPush,
    input  logic [WIDTH-1:0] iPushData,
    input  logic             iPop,
    input  logic             iClrOvr,
    output logic [WIDTH-1:0] oData,
    output logic             oEmpty,
    output logic             oFull,
    output logic             oOverrun
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wrPtr;
    logic [AW:0]      rdPtr;
    logic             doPop;
    logic             doPush;

    assign oEmpty = (wrPtr == rdPtr);
    assign oFull  = (wrPtr[AW-1:0] == rdPtr[AW-1:0]) && (wrPtr[AW] != rdPtr[AW]);
    assign doPop  = iPop && !oEmpty;
    // A pop in the same cycle frees the slot, so a push into a full FIFO still lands.
    assign doPush = iPush && (!oFull || doPop);
    assign oData  = mem[rdPtr[AW-1:0]];

    always_ff @(posedge iClk or negedge iRst_N) begin
        if (!iRst_N) begin
            wrPtr    <= '0;
            rdPtr    <= '0;
            oOverrun <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (doPush) begin
                mem[wrPtr[AW-1:0]] <= iPushData;
                wrPtr              <= wrPtr + 1'b1;
            end
            if (doPop) begin
                rdPtr <= rdPtr + 1'b1;
            end
            if (iPush && !doPush) begin
                oOverrun <= 1'b1;
            end else if (iClrOvr) begin
                oOverrun <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/zir_uart_rx.sv
// UART receiver: sync + majority filter, mid-bit sampling FSM, FWFT FIFO.
// Define ZIR_UART_RX_PARITY_EN for 8-E-1; otherwise 8-N-1 and oParityErr is tied low.
module zir_uart_rx
    import zir_uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = CLKS_PER_BIT_48M_115200,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic                   iClk,
    input  logic                   iRst_N,
    input  logic                   iRxD,
    input  logic                   iRdEn,
    input  logic                   iClrOvr,
    output logic [UART_DATA_W-1:0] oData,
    output logic                   oEmpty,
    output logic                   oFull,
    output logic                   oBusy,
    output logic                   oFrameErr,
    output logic                   oParityErr,
    output logic                   oOverrun
);

    localparam int              CNT_W     = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] HALF_LOAD = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CNT_W-1:0] FULL_LOAD = CNT_W'(CLKS_PER_BIT - 1);

    logic                   sync1;
    logic                   sync2;
    logic [1:0]             hist;
    logic                   rxF;
    logic                   rxPrev;
    logic [1:0]             warmCnt;
    rxState_t               state;
    logic [CNT_W-1:0]       bitCnt;
    logic [2:0]             bitIdx;
    logic [UART_DATA_W-1:0] shReg;
    logic                   tick;
    logic                   push;
    logic                   parBad;

    assign rxF  = (sync2 & hist[0]) | (sync2 & hist[1]) | (hist[0] & hist[1]);
    assign tick = (bitCnt == '0);

    // rxPrev stays low until the filter holds real pin samples, so a line that is
    // low when reset releases is never mistaken for a start edge.
    always_ff @(posedge iClk or negedge iRst_N) begin
        if (!iRst_N) begin
            sync1   <= 1'b1;
            sync2   <= 1'b1;
            hist    <= 2'b11;
            rxPrev  <= 1'b0;
            warmCnt <= 2'd0;
        end else begin
            sync1  <= iRxD;
            sync2  <= sync1;
            hist   <= {hist[0], sync2};
            rxPrev <= (warmCnt == 2'd3) && rxF;
            if (warmCnt != 2'd3) begin
                warmCnt <= warmCnt + 2'd1;
            end
        end
    end

`ifdef ZIR_UART_RX_PARITY_EN
    logic parAcc;
    logic parityErr;

    assign oParityErr = parityErr;
`else
    assign parBad     = 1'b0;
    assign oParityErr = 1'b0;
`endif

    always_ff @(posedge iClk or negedge iRst_N) begin
        if (!iRst_N) begin
            state     <= ST_IDLE;
            bitCnt    <= '0;
            bitIdx    <= '0;
            shReg     <= '0;
            oFrameErr <= 1'b0;
`ifdef ZIR_UART_RX_PARITY_EN
            parAcc    <= 1'b0;
            parBad    <= 1'b0;
            parityErr <= 1'b0;
`endif
        end else begin
            oFrameErr <= 1'b0;
`ifdef ZIR_UART_RX_PARITY_EN
            parityErr <= 1'b0;
`endif
            if ((state inside {ST_START, ST_DATA, ST_PARITY, ST_STOP}) && !tick) begin
                bitCnt <= bitCnt - 1'b1;
            end
            case (state)
                ST_IDLE: begin
                    if (rxPrev && !rxF) begin
                        bitCnt <= HALF_LOAD;
                        state  <= ST_START;
                    end
                end
                ST_START: begin
                    if (tick) begin
                        if (!rxF) begin
                            bitCnt <= FULL_LOAD;
                            bitIdx <= '0;
`ifdef ZIR_UART_RX_PARITY_EN
                            parAcc <= 1'b0;
                            parBad <= 1'b0;
`endif
                            state  <= ST_DATA;
                        end else begin
                            state <= ST_IDLE;
                        end
                    end
                end
                ST_DATA: begin
                    if (tick) begin
                        shReg  <= {rxF, shReg[UART_DATA_W-1:1]};
                        bitCnt <= FULL_LOAD;
                        bitIdx <= bitIdx + 3'd1;
`ifdef ZIR_UART_RX_PARITY_EN
                        parAcc <= parAcc ^ rxF;
                        if (bitIdx == 3'd7) state <= ST_PARITY;
`else
                        if (bitIdx == 3'd7) state <= ST_STOP;
`endif
                    end
                end
`ifdef ZIR_UART_RX_PARITY_EN
                ST_PARITY: begin
                    if (tick) begin
                        parBad <= parAcc ^ rxF;
                        bitCnt <= FULL_LOAD;
                        state  <= ST_STOP;
                    end
                end
`endif
                ST_STOP: begin
                    if (tick) begin
                        if (rxF) begin
`ifdef ZIR_UART_RX_PARITY_EN
                            parityErr <= parBad;
`endif
                            state <= ST_IDLE;
                        end else begin
                            oFrameErr <= 1'b1;
                            state     <= ST_BREAK;
                        end
                    end
                end
                ST_BREAK: begin
                    if (rxF) state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign oBusy = (state != ST_IDLE);
    assign push  = (state == ST_STOP) && tick && rxF && !parBad;

    zir_uart_rx_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (UART_DATA_W)
    ) uFifo (
        .iClk      (iClk),
        .iRst_N    (iRst_N),
        .iPush     (push),
        .iPushData (shReg),
        .iPop      (iRdEn),
        .iClrOvr   (iClrOvr),
        .oData     (oData),
        .oEmpty    (oEmpty),
        .oFull     (oFull),
        .oOverrun  (oOverrun)
    );

endmodule

// File: tb/tb_zir_uart_rx.sv
// Directed bench for zir_uart_rx at 16 clocks per bit; inputs driven and outputs sampled on negedge.
module tb_zir_uart_rx;
    import zir_uart_pkg::*;

    localparam int CPB = 16;

    logic       clk;
    logic       rst_n;
    logic       rx_d;
    logic       rd_en;
    logic       clr_ovr;
    logic [7:0] data;
    logic       empty;
    logic       full;
    logic       busy;
    logic       frame_err;
    logic       parity_err;
    logic       overrun;

    int checks;
    int errors;
    int frame_pulses;
    int frame_high;
    int parity_pulses;
    int parity_high;
    logic frame_d;
    logic parity_d;

    zir_uart_rx #(
        .CLKS_PER_BIT (CPB),
        .FIFO_DEPTH   (4)
    ) dut (
        .iClk       (clk),
        .iRst_N     (rst_n),
        .iRxD       (rx_d),
        .iRdEn      (rd_en),
        .iClrOvr    (clr_ovr),
        .oData      (data),
        .oEmpty     (empty),
        .oFull      (full),
        .oBusy      (busy),
        .oFrameErr  (frame_err),
        .oParityErr (parity_err),
        .oOverrun   (overrun)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // error pulse monitors: count rising edges and total high cycles
    initial begin
        frame_pulses = 0; frame_high = 0; parity_pulses = 0; parity_high = 0;
        frame_d = 1'b0; parity_d = 1'b0;
    end
    always @(negedge clk) begin
        if (frame_err) frame_high++;
        if (frame_err && !frame_d) frame_pulses++;
        if (parity_err) parity_high++;
        if (parity_err && !parity_d) parity_pulses++;
        frame_d  = frame_err;
        parity_d = parity_err;
    end

    // driver tasks
    task automatic bit_time(input logic v);
        rx_d = v;
        repeat (CPB) @(negedge clk);
    endtask

    task automatic send_frame(input logic [7:0] d, input logic stop_v, input logic par_flip);
        bit_time(1'b0);
        for (int i = 0; i < 8; i++) bit_time(d[i]);
`ifdef ZIR_UART_RX_PARITY_EN
        bit_time((^d) ^ par_flip);
`else
        if (par_flip) rx_d = rx_d;
`endif
        bit_time(stop_v);
    endtask

    task automatic do_pop();
        rd_en = 1'b1;
        @(negedge clk);
        rd_en = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; rx_d = 1'b1; rd_en = 1'b0; clr_ovr = 1'b0;
        repeat (3) @(negedge clk);
        checks++; if (data !== 8'h00) begin errors++; $display("FAIL reset_data got %h want 00", data); end
        checks++; if (empty !== 1'b1) begin errors++; $display("FAIL reset_empty got %b want 1", empty); end
        checks++; if (full !== 1'b0) begin errors++; $display("FAIL reset_full got %b want 0", full); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
        checks++; if (frame_err !== 1'b0) begin errors++; $display("FAIL reset_frame_err got %b want 0", frame_err); end
        checks++; if (parity_err !== 1'b0) begin errors++; $display("FAIL reset_parity_err got %b want 0", parity_err); end
        checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL reset_overrun got %b want 0", overrun); end
        rst_n = 1'b1;
        repeat (10) @(negedge clk);
        checks++; if (busy !== 1'b0 || empty !== 1'b1) begin errors++; $display("FAIL post_reset_idle got busy=%b empty=%b want 0/1", busy, empty); end
    endtask

    task automatic test_back_to_back();
        int fp;
        fp = frame_pulses;
        fork
            send_frame(8'hA5, 1'b1, 1'b0);
            begin
                repeat (155) @(negedge clk);
                checks++; if (empty !== 1'b1) begin errors++; $display("FAIL b2b_empty_before_push got %b want 1", empty); end
                @(negedge clk);
                checks++; if (empty !== 1'b0) begin errors++; $display("FAIL b2b_empty_after_push got %b want 0", empty); end
            end
        join
        send_frame(8'h3C, 1'b1, 1'b0);
        repeat (CPB) @(negedge clk);
        checks++; if (empty !== 1'b0 || data !== 8'hA5) begin errors++; $display("FAIL b2b_first got %h empty=%b want a5", data, empty); end
        do_pop();
        checks++; if (empty !== 1'b0 || data !== 8'h3C) begin errors++; $display("FAIL b2b_second got %h empty=%b want 3c", data, empty); end
        do_pop();
        checks++; if (empty !== 1'b1) begin errors++; $display("FAIL b2b_drained got %b want 1", empty); end
        checks++; if (frame_pulses !== fp || parity_pulses !== 0) begin errors++; $display("FAIL b2b_no_err got fe=%0d pe=%0d want %0d/0", frame_pulses, parity_pulses, fp); end
    endtask

    task automatic test_glitch();
        int fp;
        fp = frame_pulses;
        rx_d = 1'b0;
        repeat (5) @(negedge clk);
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL glitch_start got busy=%b want 1", busy); end
        rx_d = 1'b1;
        repeat (30) @(negedge clk);
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL glitch_idle got busy=%b want 0", busy); end
        checks++; if (empty !== 1'b1) begin errors++; $display("FAIL glitch_no_push got empty=%b want 1", empty); end
        checks++; if (frame_pulses !== fp) begin errors++; $display("FAIL glitch_no_fe got %0d want %0d", frame_pulses, fp); end
    endtask

    task automatic test_frame_break();
        int fp;
        int fh;
        fp = frame_pulses;
        fh = frame_high;
        send_frame(8'h55, 1'b0, 1'b0);
        repeat (40 * CPB) @(negedge clk);
        checks++; if (frame_pulses !== fp + 1 || frame_high !== fh + 1) begin errors++; $display("FAIL break_fe_pulse got pulses=%0d high=%0d want %0d/%0d", frame_pulses - fp, frame_high - fh, 1, 1); end
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL break_busy got %b want 1", busy); end
        checks++; if (empty !== 1'b1) begin errors++; $display("FAIL break_no_push got empty=%b want 1", empty); end
        rx_d = 1'b1;
        repeat (8) @(negedge clk);
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL break_release got busy=%b want 0", busy); end
        repeat (CPB) @(negedge clk);
        send_frame(8'h0F, 1'b1, 1'b0);
        repeat (CPB) @(negedge clk);
        checks++; if (empty !== 1'b0 || data !== 8'h0F) begin errors++; $display("FAIL break_recover got %h empty=%b want 0f", data, empty); end
        do_pop();
    endtask

    task automatic test_overrun();
        for (int i = 1; i <= 4; i++) send_frame(8'(i), 1'b1, 1'b0);
        repeat (CPB) @(negedge clk);
        checks++; if (full !== 1'b1 || overrun !== 1'b0) begin errors++; $display("FAIL ovr_full got full=%b ovr=%b want 1/0", full, overrun); end
        send_frame(8'h05, 1'b1, 1'b0);
        repeat (CPB) @(negedge clk);
        checks++; if (overrun !== 1'b1) begin errors++; $display("FAIL ovr_set got %b want 1", overrun); end
        for (int i = 1; i <= 4; i++) begin
            checks++; if (empty !== 1'b0 || data !== 8'(i)) begin errors++; $display("FAIL ovr_pop%0d got %h empty=%b want %h", i, data, empty, 8'(i)); end
            do_pop();
        end
        checks++; if (empty !== 1'b1) begin errors++; $display("FAIL ovr_drained got %b want 1", empty); end
        clr_ovr = 1'b1;
        @(negedge clk);
        clr_ovr = 1'b0;
        checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL ovr_clear got %b want 0", overrun); end
    endtask

    task automatic test_full_pop();
        for (int i = 1; i <= 4; i++) send_frame(8'(i), 1'b1, 1'b0);
        fork
            send_frame(8'h05, 1'b1, 1'b0);
            begin
                repeat (155) @(negedge clk);
                rd_en = 1'b1;
                @(negedge clk);
                rd_en = 1'b0;
            end
        join
        repeat (CPB) @(negedge clk);
        checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL fullpop_no_ovr got %b want 0", overrun); end
        checks++; if (full !== 1'b1) begin errors++; $display("FAIL fullpop_full got %b want 1", full); end
        for (int i = 2; i <= 5; i++) begin
            checks++; if (empty !== 1'b0 || data !== 8'(i)) begin errors++; $display("FAIL fullpop_pop%0d got %h empty=%b want %h", i, data, empty, 8'(i)); end
            do_pop();
        end
        checks++; if (empty !== 1'b1) begin errors++; $display("FAIL fullpop_drained got %b want 1", empty); end
    endtask

`ifdef ZIR_UART_RX_PARITY_EN
    task automatic test_parity();
        int pp;
        int ph;
        pp = parity_pulses;
        ph = parity_high;
        send_frame(8'h07, 1'b1, 1'b1);
        repeat (CPB) @(negedge clk);
        checks++; if (parity_pulses !== pp + 1 || parity_high !== ph + 1) begin errors++; $display("FAIL parity_pulse got pulses=%0d high=%0d want 1/1", parity_pulses - pp, parity_high - ph); end
        checks++; if (empty !== 1'b1) begin errors++; $display("FAIL parity_no_push got empty=%b want 1", empty); end
    endtask
`endif

    task automatic test_reset_midframe();
        send_frame(8'h99, 1'b1, 1'b0);
        repeat (CPB) @(negedge clk);
        checks++; if (empty !== 1'b0 || data !== 8'h99) begin errors++; $display("FAIL midrst_preload got %h empty=%b want 99", data, empty); end
        bit_time(1'b0);
        for (int i = 0; i < 4; i++) bit_time(1'b1);
        rx_d = 1'b0;
        repeat (6) @(negedge clk);
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL midrst_busy got %b want 1", busy); end
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        checks++; if (data !== 8'h00 || empty !== 1'b1 || full !== 1'b0 || busy !== 1'b0 ||
                      frame_err !== 1'b0 || parity_err !== 1'b0 || overrun !== 1'b0) begin
            errors++;
            $display("FAIL midrst_values got data=%h e=%b f=%b b=%b fe=%b pe=%b ov=%b want 00 1 0 0 0 0 0",
                     data, empty, full, busy, frame_err, parity_err, overrun);
        end
        rst_n = 1'b1;
        repeat (CPB - 8) @(negedge clk);
        for (int i = 5; i < 8; i++) bit_time(1'b0);
`ifdef ZIR_UART_RX_PARITY_EN
        bit_time(1'b0);
`endif
        bit_time(1'b1);
        repeat (3 * CPB) @(negedge clk);
        checks++; if (empty !== 1'b1 || busy !== 1'b0) begin errors++; $display("FAIL midrst_no_spurious got empty=%b busy=%b want 1/0", empty, busy); end
        send_frame(8'h5A, 1'b1, 1'b0);
        repeat (CPB) @(negedge clk);
        checks++; if (empty !== 1'b0 || data !== 8'h5A) begin errors++; $display("FAIL midrst_recover got %h empty=%b want 5a", data, empty); end
        do_pop();
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_back_to_back();
        test_glitch();
        test_frame_break();
        test_overrun();
        test_full_pop();
`ifdef ZIR_UART_RX_PARITY_EN
        test_parity();
`endif
        test_reset_midframe();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
